// File: rtl/scan_decoder.sv
// Registered AW-to-2^AW one-hot decoder with enable, direct/scan modes and prescaled scan.
// Optional SCAN_DIR_EN macro adds a dir input for down-counting scans.
module scan_decoder #(
  parameter int unsigned AW         = 3,
  parameter int unsigned PRESCALE   = 4,
  parameter bit          ACTIVE_LOW = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 mode,
`ifdef SCAN_DIR_EN
  input  logic                 dir,
`endif
  input  logic [AW-1:0]        a,
  output logic [(2**AW)-1:0]   y,
  output logic [AW-1:0]        idx,
  output logic                 wrap
);

  localparam int unsigned    N       = 2**AW;
  localparam int unsigned    PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]  PC_LAST = PW'(PRESCALE - 1);
  localparam logic [AW-1:0]  IDX_MAX = '1;

  logic [PW-1:0] pc_q, pc_d, pc_cur;
  logic [AW-1:0] idx_q, idx_d;
  logic [N-1:0]  y_q, y_d, onehot;
  logic          wrap_q, wrap_d;
  logic          prev_mode_q, prev_mode_d;
  logic          down;

`ifdef SCAN_DIR_EN
  assign down = dir;
`else
  assign down = 1'b0;
`endif

  always_comb begin
    pc_d        = pc_q;
    idx_d       = idx_q;
    wrap_d      = 1'b0;
    prev_mode_d = prev_mode_q;
    onehot      = '0;
    y_d         = ACTIVE_LOW ? '1 : '0;
    // First enabled scan cycle after direct mode always counts from pc = 0.
    pc_cur      = (mode && !prev_mode_q) ? '0 : pc_q;
    if (en) begin
      prev_mode_d = mode;
      if (!mode) begin
        idx_d = a;
        pc_d  = '0;
      end else if (pc_cur == PC_LAST) begin
        pc_d = '0;
        if (down) begin
          idx_d  = idx_q - 1'b1;
          wrap_d = (idx_q == '0);
        end else begin
          idx_d  = idx_q + 1'b1;
          wrap_d = (idx_q == IDX_MAX);
        end
      end else begin
        pc_d = pc_cur + 1'b1;
      end
      onehot[idx_d] = 1'b1;
      y_d = ACTIVE_LOW ? ~onehot : onehot;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q        <= '0;
      idx_q       <= '0;
      wrap_q      <= 1'b0;
      prev_mode_q <= 1'b0;
      y_q         <= ACTIVE_LOW ? '1 : '0;
    end else begin
      pc_q        <= pc_d;
      idx_q       <= idx_d;
      wrap_q      <= wrap_d;
      prev_mode_q <= prev_mode_d;
      y_q         <= y_d;
    end
  end

  assign y    = y_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: vector table on an AW=3/PRESCALE=4 instance, hand sequences on an
// ACTIVE_LOW AW=2/PRESCALE=1 instance, and a down-scan sequence when SCAN_DIR_EN is defined.
module tb_scan_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst1, en1, mode1;
  logic [2:0] a1;
  logic [7:0] y1;
  logic [2:0] idx1;
  logic       wrap1;

  logic       rst2, en2, mode2;
  logic [1:0] a2;
  logic [3:0] y2;
  logic [1:0] idx2;
  logic       wrap2;

`ifdef SCAN_DIR_EN
  logic dir1, dir2;
`endif

  scan_decoder #(.AW(3), .PRESCALE(4), .ACTIVE_LOW(1'b0)) u_dut1 (
    .clk(clk), .rst(rst1), .en(en1), .mode(mode1),
`ifdef SCAN_DIR_EN
    .dir(dir1),
`endif
    .a(a1), .y(y1), .idx(idx1), .wrap(wrap1)
  );

  scan_decoder #(.AW(2), .PRESCALE(1), .ACTIVE_LOW(1'b1)) u_dut2 (
    .clk(clk), .rst(rst2), .en(en2), .mode(mode2),
`ifdef SCAN_DIR_EN
    .dir(dir2),
`endif
    .a(a2), .y(y2), .idx(idx2), .wrap(wrap2)
  );

  typedef struct {
    logic        rst;
    logic        en;
    logic        mode;
    logic [2:0]  a;
    int unsigned n;
    logic [7:0]  y;
    logic [2:0]  idx;
    logic        wrap;
    string       name;
  } vec_t;

  typedef struct {
    int unsigned dut;
    string       name;
    logic [7:0]  y;
    logic [2:0]  idx;
    logic        wrap;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(input logic r, input logic e, input logic m, input logic [2:0] a,
                              input int unsigned n, input logic [7:0] y, input logic [2:0] i,
                              input logic w, input string name);
    vec_t v;
    v.rst = r; v.en = e; v.mode = m; v.a = a; v.n = n;
    v.y = y; v.idx = i; v.wrap = w; v.name = name;
    return v;
  endfunction

  task automatic expect_clock(input int unsigned dut, input string name, input logic [7:0] y,
                              input logic [2:0] i, input logic w);
    exp_t e;
    logic [7:0] ay;
    logic [2:0] ai;
    logic       aw;
    e.dut = dut; e.name = name; e.y = y; e.idx = i; e.wrap = w;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      if (e.dut == 1) begin
        ay = y1; ai = idx1; aw = wrap1;
      end else begin
        ay = {4'h0, y2}; ai = {1'b0, idx2}; aw = wrap2;
      end
      if (ay !== e.y || ai !== e.idx || aw !== e.wrap) begin
        errors++;
        $display("FAIL %s: got y=%h idx=%0d wrap=%b, expected y=%h idx=%0d wrap=%b",
                 e.name, ay, ai, aw, e.y, e.idx, e.wrap);
      end
    end
  endtask

  initial begin
    logic [7:0] one8;
    logic [3:0] one4;
    logic [2:0] ei;

    rst1 = 1'b1; en1 = 1'b0; mode1 = 1'b0; a1 = '0;
    rst2 = 1'b1; en2 = 1'b0; mode2 = 1'b0; a2 = '0;
`ifdef SCAN_DIR_EN
    dir1 = 1'b0; dir2 = 1'b0;
`endif
    one8 = 8'h01;
    one4 = 4'h1;

    tbl.push_back(mk(1, 0, 0, 0, 2, 8'h00, 0, 0, "reset"));
    tbl.push_back(mk(0, 1, 0, 5, 1, 8'h20, 5, 0, "direct_a5"));
    tbl.push_back(mk(0, 1, 0, 0, 1, 8'h01, 0, 0, "direct_a0"));
    tbl.push_back(mk(0, 1, 0, 3, 1, 8'h08, 3, 0, "direct_a3"));
    tbl.push_back(mk(0, 0, 0, 3, 3, 8'h00, 3, 0, "en_low"));
    tbl.push_back(mk(0, 1, 0, 3, 1, 8'h08, 3, 0, "en_back"));
    tbl.push_back(mk(0, 1, 0, 6, 1, 8'h40, 6, 0, "direct_a6"));
    tbl.push_back(mk(0, 1, 1, 2, 3, 8'h40, 6, 0, "scan_hold6"));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h80, 7, 0, "scan_step7"));
    tbl.push_back(mk(0, 1, 1, 2, 3, 8'h80, 7, 0, "scan_hold7"));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h01, 0, 1, "scan_wrap"));
    tbl.push_back(mk(0, 1, 1, 2, 3, 8'h01, 0, 0, "scan_hold0"));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h02, 1, 0, "scan_step1"));
    tbl.push_back(mk(0, 1, 1, 2, 3, 8'h02, 1, 0, "scan_hold1"));
    tbl.push_back(mk(0, 1, 1, 2, 4, 8'h04, 2, 0, "scan_idx2"));
    tbl.push_back(mk(0, 1, 1, 2, 4, 8'h08, 3, 0, "scan_idx3"));
    tbl.push_back(mk(0, 1, 1, 2, 3, 8'h10, 4, 0, "scan_idx4"));
    tbl.push_back(mk(1, 1, 1, 2, 1, 8'h00, 0, 0, "reset_midscan"));
    tbl.push_back(mk(0, 1, 1, 2, 3, 8'h01, 0, 0, "post_reset_hold"));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h02, 1, 0, "post_reset_step"));
    tbl.push_back(mk(0, 1, 0, 5, 1, 8'h20, 5, 0, "scan_to_direct"));
    tbl.push_back(mk(0, 1, 1, 2, 2, 8'h20, 5, 0, "rescan"));
    tbl.push_back(mk(0, 0, 1, 2, 3, 8'h00, 5, 0, "scan_frozen"));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h20, 5, 0, "scan_resume"));
    tbl.push_back(mk(0, 1, 1, 2, 1, 8'h40, 6, 0, "resume_step"));

    foreach (tbl[r]) begin
      for (int unsigned k = 0; k < tbl[r].n; k++) begin
        rst1 = tbl[r].rst; en1 = tbl[r].en; mode1 = tbl[r].mode; a1 = tbl[r].a;
        expect_clock(1, tbl[r].name, tbl[r].y, tbl[r].idx, tbl[r].wrap);
      end
    end

    // Active-low, PRESCALE=1, AW=2 instance.
    rst1 = 1'b1;
    rst2 = 1'b1;
    expect_clock(2, "al_reset", 8'h0F, 0, 0);
    rst2 = 1'b0; en2 = 1'b1; mode2 = 1'b0; a2 = 2'd0;
    expect_clock(2, "al_direct0", 8'h0E, 0, 0);
    mode2 = 1'b1;
    for (int unsigned c = 1; c <= 8; c++) begin
      ei = 3'(c % 4);
      expect_clock(2, "al_scan", {4'h0, ~(one4 << ei)}, ei, (ei == 3'd0));
    end
    en2 = 1'b0;
    expect_clock(2, "al_disabled", 8'h0F, 0, 0);

`ifdef SCAN_DIR_EN
    rst1 = 1'b0; en1 = 1'b1; mode1 = 1'b0; a1 = 3'd1; dir1 = 1'b1;
    expect_clock(1, "dir_load1", 8'h02, 1, 0);
    mode1 = 1'b1;
    for (int unsigned c = 1; c <= 12; c++) begin
      ei = (c < 4) ? 3'd1 : (c < 8) ? 3'd0 : (c < 12) ? 3'd7 : 3'd6;
      expect_clock(1, "dir_down", one8 << ei, ei, (c == 8));
    end
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d left, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_decoder.md
Name: scan_decoder

Overview:
Parametrised registered AW-to-2^AW one-hot decoder with enable and two modes.
- Direct mode: decodes an input address.
- Scan mode: an internal prescaled counter walks the active output across all lines; used for multiplexed digit/LED select.
- Next generation of the team's fixed 3-to-8 combinational decoder. Adds width generality, registered outputs, enable and autonomous scanning.

Parameters:
AW, 3, address width; output width is 2^AW (AW >= 1)
PRESCALE, 4, clock cycles per scan step (>= 1)
ACTIVE_LOW, 0, 1 = output lines active-low (active line 0, others 1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
en  input  1  1 = outputs active; 0 = all lines inactive, scan frozen
mode  input  1  0 = direct decode of a; 1 = auto scan
a  input  AW  address in direct mode (ignored in scan mode)
y  output  2^AW  registered one-hot (or one-cold if ACTIVE_LOW) select
idx  output  AW  registered index of current/selected line
wrap  output  1  one-cycle pulse when scan index wraps

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset, sampled at the clk edge: y = all inactive (0s, or 1s if ACTIVE_LOW), idx = 0, wrap = 0, prescaler count pc = 0.
- Reset asserted mid-scan clears everything at the next edge and overrides en and mode.
- Internal state: pc, width clog2(PRESCALE) (minimum 1), range 0..PRESCALE-1; idx register; prev_mode register.
- Direct mode (mode=0, en=1):
  - idx <= a; y <= line a active, all others inactive.
  - Latency one cycle from a to y.
  - pc held at 0; wrap = 0.
- Scan mode (mode=1, en=1):
  - pc increments each cycle.
  - When pc = PRESCALE-1: pc <= 0 and idx <= idx+1 modulo 2^AW.
  - When idx goes from 2^AW-1 to 0, wrap = 1 for exactly that one cycle (registered with the idx update); otherwise wrap = 0.
  - y always reflects the registered idx in the same cycle: y = decode(idx).
- Mode transition 0->1: pc cleared to 0 on the first scan cycle. Scanning starts from the idx last loaded in direct mode; the first step occurs PRESCALE cycles after entry.
- Mode transition 1->0: idx <= a on that edge; scan position is discarded.
- en=0, either mode:
  - y <= all inactive next cycle.
  - idx and pc hold their values; wrap = 0.
  - When en returns to 1, y shows decode(idx) on the next edge and the scan resumes from the held pc.
- PRESCALE=1: idx steps every cycle, and wrap pulses every 2^AW cycles.
- AW=1: a 1-to-2 decoder; idx toggles in scan mode and wrap fires on every 1->0 step.
- Invariant: with en=1, exactly one line of y is active (one-hot or one-cold). With en=0 or after reset, none is active.
- ACTIVE_LOW applies only to the final y register polarity. idx and wrap are unaffected.

Optional Feature:
SCAN_DIR_EN
- Defined: adds input port dir (1 bit), placed after mode.
  - dir=0: scan counts up, as above.
  - dir=1: scan counts down; idx goes 0 -> 2^AW-1 and wrap pulses on that step.
  - dir is sampled only at step edges, so changing it mid-interval takes effect at the next step.
  - dir is ignored in direct mode.
- Not defined: no dir port; scan is up-only. Behaviour is otherwise identical.

Test Plan:
- Reset then direct decode: rst=1 for 2 cycles, then en=1, mode=0, a=5 (AW=3) -> one cycle later y=8'b0010_0000, idx=5; a=0 -> next cycle y=8'b0000_0001.
- Enable gating: direct mode, a=3, en dropped to 0 for 3 cycles -> y=8'h00 from the next edge and idx stays 3; en=1 -> y=8'b0000_1000 next cycle.
- Scan with PRESCALE=4: a=6 loaded, then mode=1 -> idx=7 after 4 cycles; idx=0 with wrap=1 for one cycle after 8 cycles; idx=1 after 12 cycles with wrap=0.
- Reset mid-scan: assert rst while idx=4, pc=2 -> next edge y=0, idx=0, pc=0, wrap=0; deassert -> scan restarts at idx=0, stepping after 4 cycles.
- ACTIVE_LOW=1, PRESCALE=1, AW=2, scan mode: y cycles 4'b1110, 1101, 1011, 0111, 1110 and wrap=1 on every 4th cycle.
- SCAN_DIR_EN defined, dir=1, PRESCALE=1, start idx=1 -> idx sequence 0, 7 (wrap=1), 6, 5.
